// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle RV32 control FSM with variable-latency memory handshake
module mc_control_unit #(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       areset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zeroFlag,
    input  logic       signFlag,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       halted,
    output logic [1:0] halt_cause,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] cause_q, cause_d;

    logic       req_raw, ir_raw, pc_raw, rw_raw, mw_raw;
    logic       legal;
    logic [3:0] dec_next;
    logic       wait_hit;

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_op = sub ? 3'b001 : 3'b000;
            3'b010:  alu_op = 3'b101;
            3'b100:  alu_op = 3'b100;
            3'b110:  alu_op = 3'b011;
            3'b111:  alu_op = 3'b010;
            default: alu_op = 3'b000;
        endcase
    endfunction

    always_comb begin
        legal    = 1'b0;
        dec_next = S_HALT;
        case (opcode)
            OP_LOAD, OP_STORE: begin
                legal    = (funct3 == 3'b010);
                dec_next = S_MEMADR;
            end
            OP_R, OP_I: begin
                legal    = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                           (funct3 == 3'b110) || (funct3 == 3'b111);
                dec_next = (opcode == OP_R) ? S_EXECR : S_EXECI;
            end
            OP_BR: begin
                legal    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100);
                dec_next = S_BRANCH;
            end
            OP_JAL: begin
                legal    = 1'b1;
                dec_next = S_JAL;
            end
            default: begin
                legal    = 1'b0;
                dec_next = S_HALT;
            end
        endcase
    end

    always_comb begin
        case (opcode)
            OP_STORE: ImmSrc = 2'b01;
            OP_BR:    ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    assign req_raw  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    // Timeout fires on the cycle that would complete the WAIT_LIMIT-th stalled cycle.
    assign wait_hit = (WAIT_LIMIT != 0) && req_raw && !mem_ready && (wait_q == LIMIT_M1);

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        ir_raw     = 1'b0;
        pc_raw     = 1'b0;
        rw_raw     = 1'b0;
        mw_raw     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_raw    = mem_ready;
                pc_raw    = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (legal) begin
                    state_d = dec_next;
                end else begin
                    state_d = S_HALT;
                    cause_d = 2'b01;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                rw_raw    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mw_raw = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_op(funct3, (state_q == S_EXECR) && funct7);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                rw_raw  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                pc_raw     = ((funct3 == 3'b000) && zeroFlag) ||
                             ((funct3 == 3'b001) && !zeroFlag) ||
                             ((funct3 == 3'b100) && signFlag);
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pc_raw  = 1'b1;
                state_d = S_ALUWB;
            end
            default: state_d = S_HALT;
        endcase
        if (wait_hit) begin
            state_d = S_HALT;
            cause_d = 2'b10;
            ir_raw  = 1'b0;
            pc_raw  = 1'b0;
            mw_raw  = 1'b0;
        end
    end

    always_comb begin
        wait_d = 8'd0;
        if (req_raw && !mem_ready) wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    // Strobes are gated by the reset pin so an asserted reset kills any access at once.
    assign mem_req    = req_raw & areset;
    assign IRWrite    = ir_raw & areset;
    assign PCWrite    = pc_raw & areset;
    assign RegWrite   = rw_raw & areset;
    assign MemWrite   = mw_raw & areset;
    assign halted     = (state_q == S_HALT);
    assign halt_cause = cause_q;
    assign state      = state_q;

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle control FSM for the RV32 core: sequences a shared-memory, multicycle datapath (one ALU, one memory port, instruction register, ALUOut/Data/OldPC registers) in place of the single-cycle CU. It decodes the held instruction fields, generates every datapath enable and mux select per state, and handshakes with a memory port of variable latency. Illegal encodings or a memory timeout halt the core until reset.

## Interface
- WAIT_LIMIT, default 0: maximum consecutive cycles with mem_req=1 and mem_ready=0; 0 = unlimited; otherwise 1..255.
- clk  in  1  single clock; all state changes on rising edge.
- areset  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0]; funct3 in 3 IR[14:12]; funct7 in 1 IR[30]. Valid from DECODE onward.
- zeroFlag, signFlag  in  1  ALU flags, combinational from current ALU inputs.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested (FETCH, MEMREAD, MEMWRITE).
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address.
- IRWrite, PCWrite, RegWrite, MemWrite  out  1  register/memory write enables.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register A.
- ALUSrcB  out  2  00 rs2 register B, 01 ImmExt, 10 constant 4.
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- halted  out  1  core stopped; halt_cause out 2: 00 none, 01 illegal encoding, 10 memory timeout.
- state  out  4  current state code, for debug.

## Operation
- States (code): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, HALT 11. Outputs are Moore (state-decoded) except PCWrite in BRANCH and the mem_ready-qualified strobes. All outputs not listed for a state are 0; ImmSrc is decoded from opcode in every state.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=mem_ready. mem_ready=1 -> DECODE, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target into ALUOut). Next: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; any other opcode (including all-zero) -> HALT, cause 01.
- Legal funct3: ALU ops 000, 010, 100, 110, 111; load/store 010 only; branch 000 (beq), 001 (bne), 100 (blt). Anything else -> HALT from DECODE, cause 01.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add -> MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, AdrSrc=1; wait for mem_ready -> MEMWB. MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=mem_ready held with request; mem_ready -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00; ALUControl from funct3 (000 add, or sub when funct7=1; 010 slt; 100 xor; 110 or; 111 and) -> ALUWB. EXECI: same with ALUSrcB=01, funct7 ignored -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite = beq&zeroFlag | bne&!zeroFlag | blt&signFlag -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (writes PC+4 to rd).
- HALT: absorbing; all strobes and mem_req 0; halted=1; halt_cause held. Only areset exits.
- Wait counter (8-bit): clears on entering any request state and on mem_ready; increments while mem_req=1 and mem_ready=0; reaching WAIT_LIMIT (when nonzero) -> HALT, cause 10, with no write strobe that cycle.

## Timing
- Reset (areset=0, asynchronous): state=FETCH, counter=0, halted=0, halt_cause=00. While areset=0, mem_req, IRWrite, PCWrite, RegWrite and MemWrite are forced 0.
- Reset asserted mid-instruction aborts it immediately; no partial write is issued after assertion.
- Handshake: mem_req holds until the rising edge at which mem_ready=1. mem_ready is ignored when mem_req=0.
- Latency with zero-wait memory: R/I/JAL 4 cycles, load 5, store 4, branch 3.
- Every additional cycle of mem_ready=0 adds exactly one cycle.

## Test plan
- Reset release, then add x3,x1,x2 with mem_ready tied 1 -> states 0,1,6,8; RegWrite=1 in ALUWB only; ALUControl=000.
- lw with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1; total 8 cycles.
- Branches: beq with zeroFlag=1 -> PCWrite=1; bne with zeroFlag=1 -> PCWrite=0; blt with signFlag=1 -> PCWrite=1. Each takes 3 cycles.
- Instruction 0x00000000, then funct3=001 on opcode 0110011 -> each goes HALT from DECODE with halted=1, cause 01, and all strobes 0 for 20 subsequent cycles.
- WAIT_LIMIT=4 with mem_ready stuck 0 in FETCH -> HALT after 4 wait cycles, cause 10, IRWrite never 1.
- areset pulsed low during MEMWRITE wait -> MemWrite drops the same cycle; state=FETCH; a clean fetch follows.
